spi_bus_arbiter: RTL and testbench

- Shares the single SPI pin set (SCLK, MOSI, flash SS, sensor SS) between the flash SPI master and the light-sensor SPI master.
- Sits between the FSM and the two SPI masters. It forwards valid/ready handshakes only to the master that holds the bus, and muxes that master's pins onto the pads.
- Uses round-robin arbitration, inserts an idle guard gap between transactions, and enforces a timeout so a hung master cannot lock the bus.

---
 rtl/spi_bus_arbiter_pkg.sv | 21 ++
 rtl/spi_bus_arbiter_counter.sv | 35 +++
 rtl/spi_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_bus_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_F = 2'd1,
    ST_GRANT_L = 2'd2,
    ST_GUARD   = 2'd3
  } state_e;

  // Encodings driven on grant_o.
  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_FLASH = 2'b01;
  localparam logic [1:0] GNT_LUKS  = 2'b10;

  // Default timing parameters.
  localparam int DEF_GUARD_CYCLES   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/spi_bus_arbiter_counter.sv
// Clearable saturating up-counter with a terminal-compare output, shared by
// the guard gap and the grant timeout (never active at the same time).
module arb_counter #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != {CNT_W{1'b1}}) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign hit_o = (count_q == term_i);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI pin set between the flash and the
// light-sensor SPI masters, with an idle guard gap and a grant timeout.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flash_valid_i,
  output logic       flash_ready_o,
  input  logic       luks_valid_i,
  output logic       luks_ready_o,
  output logic       flash_valid_o,
  input  logic       flash_ready_i,
  output logic       luks_valid_o,
  input  logic       luks_ready_i,
  input  logic       flash_sclk_i,
  input  logic       flash_ss_i,
  input  logic       flash_mosi_i,
  input  logic       luks_sclk_i,
  input  logic       luks_ss_i,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       flash_ss_o,
  output logic       luks_ss_o,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GD_TERM =
    CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  // Where a finished grant goes: straight to IDLE when there is no gap.
  localparam state_e ST_POST = (GUARD_CYCLES > 0) ? ST_GUARD : ST_IDLE;

  state_e     state_q, state_d;
  logic       last_luks_q, last_luks_d;   // 1: sensor was served last
  logic       flash_valid_q, flash_valid_d;
  logic       luks_valid_q, luks_valid_d;
  logic [1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_term;
  logic       cnt_clr, cnt_hit;

  // Counter restarts at zero on every state change.
  assign cnt_clr = (state_d != state_q);

  arb_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr),
    .term_i (cnt_term),
    .hit_o  (cnt_hit)
  );

  // Next-state, round-robin pointer and completion/timeout pulses.
  // NOTE: every output of this block gets a default first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    last_luks_d   = last_luks_q;
    flash_ready_o = 1'b0;
    luks_ready_o  = 1'b0;
    timeout_o     = 1'b0;
    cnt_term      = GD_TERM;
    unique case (state_q)
      ST_IDLE: begin
        if (flash_valid_i && (!luks_valid_i || last_luks_q)) state_d = ST_GRANT_F;
        else if (luks_valid_i)                               state_d = ST_GRANT_L;
      end
      ST_GRANT_F: begin
        cnt_term = TO_TERM;
        if (flash_ready_i) begin
          flash_ready_o = 1'b1;
          last_luks_d   = 1'b0;
          state_d       = ST_POST;
        end else if (cnt_hit) begin
          timeout_o   = 1'b1;
          last_luks_d = 1'b0;
          state_d     = ST_POST;
        end
      end
      ST_GRANT_L: begin
        cnt_term = TO_TERM;
        if (luks_ready_i) begin
          luks_ready_o = 1'b1;
          last_luks_d  = 1'b1;
          state_d      = ST_POST;
        end else if (cnt_hit) begin
          timeout_o   = 1'b1;
          last_luks_d = 1'b1;
          state_d     = ST_POST;
        end
      end
      ST_GUARD: begin
        if (cnt_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered start requests and grant code, derived from the next state.
  always_comb begin
    flash_valid_d = (state_d == ST_GRANT_F);
    luks_valid_d  = (state_d == ST_GRANT_L);
    grant_d       = GNT_NONE;
    if (state_d == ST_GRANT_F) grant_d = GNT_FLASH;
    if (state_d == ST_GRANT_L) grant_d = GNT_LUKS;
  end

  // State, pointer and output registers; reset releases the bus at once.
  // NOTE: reset is asynchronous so the pads drop to their idle levels
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      last_luks_q   <= 1'b1;
      flash_valid_q <= 1'b0;
      luks_valid_q  <= 1'b0;
      grant_q       <= GNT_NONE;
    end else begin
      state_q       <= state_d;
      last_luks_q   <= last_luks_d;
      flash_valid_q <= flash_valid_d;
      luks_valid_q  <= luks_valid_d;
      grant_q       <= grant_d;
    end
  end

  assign flash_valid_o = flash_valid_q;
  assign luks_valid_o  = luks_valid_q;
  assign grant_o       = grant_q;

  // Pad mux: only the owner reaches the pads; SS of the other stays high.
  always_comb begin
    spi_sclk_o = 1'b0;
    spi_mosi_o = 1'b0;
    flash_ss_o = 1'b1;
    luks_ss_o  = 1'b1;
    if (state_q == ST_GRANT_F) begin
      spi_sclk_o = flash_sclk_i;
      spi_mosi_o = flash_mosi_i;
      flash_ss_o = flash_ss_i;
    end else if (state_q == ST_GRANT_L) begin
      spi_sclk_o = luks_sclk_i;
      luks_ss_o  = luks_ss_i;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus random
// traffic, compared each cycle against a transaction-level model.
module tb_spi_bus_arbiter;

  localparam int G  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn;
  logic flash_valid_i, luks_valid_i, flash_ready_i, luks_ready_i;
  logic flash_sclk_i, flash_ss_i, flash_mosi_i, luks_sclk_i, luks_ss_i;
  logic flash_ready_o, luks_ready_o, flash_valid_o, luks_valid_o;
  logic spi_sclk_o, spi_mosi_o, flash_ss_o, luks_ss_o, timeout_o;
  logic [1:0] grant_o;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, for how long, guard cycles left.
  int m_owner;       // 0 none, 1 flash, 2 sensor
  int m_age;         // cycles already spent in the current grant
  int m_guard_left;  // guard cycles still to go
  bit m_last_luks;

  logic [1:0] obs_grant;
  logic       obs_timeout, obs_fro, obs_lro;

  spi_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO), .CNT_W(13)) dut (
    .clk(clk), .rstn(rstn),
    .flash_valid_i(flash_valid_i), .flash_ready_o(flash_ready_o),
    .luks_valid_i(luks_valid_i), .luks_ready_o(luks_ready_o),
    .flash_valid_o(flash_valid_o), .flash_ready_i(flash_ready_i),
    .luks_valid_o(luks_valid_o), .luks_ready_i(luks_ready_i),
    .flash_sclk_i(flash_sclk_i), .flash_ss_i(flash_ss_i), .flash_mosi_i(flash_mosi_i),
    .luks_sclk_i(luks_sclk_i), .luks_ss_i(luks_ss_i),
    .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o),
    .flash_ss_o(flash_ss_o), .luks_ss_o(luks_ss_o),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner      = 0;
    m_age        = 0;
    m_guard_left = 0;
    m_last_luks  = 1'b1;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic compare_outputs(input string tag);
    logic e_fro, e_lro, e_to, e_sclk, e_mosi, e_fss, e_lss;
    e_fro = (m_owner == 1) && flash_ready_i;
    e_lro = (m_owner == 2) && luks_ready_i;
    e_to  = (m_owner != 0) && (m_age == TO - 1) && !(e_fro || e_lro);
    e_sclk = 1'b0; e_mosi = 1'b0; e_fss = 1'b1; e_lss = 1'b1;
    if (m_owner == 1) begin
      e_sclk = flash_sclk_i; e_mosi = flash_mosi_i; e_fss = flash_ss_i;
    end else if (m_owner == 2) begin
      e_sclk = luks_sclk_i; e_lss = luks_ss_i;
    end
    check_vec({tag, ".grant"}, grant_o, 2'(m_owner));
    check_bit({tag, ".flash_valid_o"}, flash_valid_o, m_owner == 1);
    check_bit({tag, ".luks_valid_o"}, luks_valid_o, m_owner == 2);
    check_bit({tag, ".flash_ready_o"}, flash_ready_o, e_fro);
    check_bit({tag, ".luks_ready_o"}, luks_ready_o, e_lro);
    check_bit({tag, ".timeout"}, timeout_o, e_to);
    check_bit({tag, ".sclk"}, spi_sclk_o, e_sclk);
    check_bit({tag, ".mosi"}, spi_mosi_o, e_mosi);
    check_bit({tag, ".flash_ss"}, flash_ss_o, e_fss);
    check_bit({tag, ".luks_ss"}, luks_ss_o, e_lss);
    obs_grant   = grant_o;
    obs_timeout = timeout_o;
    obs_fro     = flash_ready_o;
    obs_lro     = luks_ready_o;
  endtask

  // Advance the model by one clock using the inputs seen at the edge.
  task automatic model_advance();
    bit rdy;
    if (m_owner != 0) begin
      rdy = (m_owner == 1) ? flash_ready_i : luks_ready_i;
      if (rdy || m_age == TO - 1) begin
        m_last_luks  = (m_owner == 2);
        m_owner      = 0;
        m_guard_left = G;
      end else begin
        m_age++;
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else begin
      if (flash_valid_i && luks_valid_i) m_owner = m_last_luks ? 1 : 2;
      else if (flash_valid_i)            m_owner = 1;
      else if (luks_valid_i)             m_owner = 2;
      m_age = 0;
    end
  endtask

  // One cycle: scramble master pins, check at negedge, advance at posedge.
  task automatic step(input string tag);
    flash_sclk_i = 1'($urandom_range(0, 1));
    flash_ss_i   = 1'($urandom_range(0, 1));
    flash_mosi_i = 1'($urandom_range(0, 1));
    luks_sclk_i  = 1'($urandom_range(0, 1));
    luks_ss_i    = 1'($urandom_range(0, 1));
    @(negedge clk);
    compare_outputs(tag);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  // Step until a grant appears, bounded.
  task automatic wait_grant(input string tag);
    for (int n = 0; n < 30; n++) begin
      step(tag);
      if (obs_grant != 2'b00) break;
    end
  endtask

  // Both slave selects must never be low together.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      checks++;
      assert (!(flash_ss_o === 1'b0 && luks_ss_o === 1'b0)) else begin
        errors++;
        $error("FAIL ss_exclusive: observed flash_ss=%b luks_ss=%b expected not both 0",
               flash_ss_o, luks_ss_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;

    rstn = 1'b0;
    {flash_valid_i, luks_valid_i, flash_ready_i, luks_ready_i} = '0;
    {flash_sclk_i, flash_ss_i, flash_mosi_i, luks_sclk_i, luks_ss_i} = '1;
    model_reset();
    #3;
    compare_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    model_advance();
    #1;

    // Single flash request, done pulse after 12 grant cycles.
    flash_valid_i = 1'b1;
    step("t1_req");
    for (int i = 0; i < 11; i++) step("t1_busy");
    flash_ready_i = 1'b1;
    step("t1_done");
    check_bit("t1_ready_same_cycle", obs_fro, 1'b1);
    flash_ready_i = 1'b0;
    flash_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step("t1_guard");

    // Fresh reset, then both requests held: flash, sensor, flash, sensor.
    rstn = 1'b0;
    model_reset();
    #2;
    rstn = 1'b1;
    flash_valid_i = 1'b1;
    luks_valid_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2_wait");
      check_vec("t2_order", obs_grant, order[k]);
      for (int i = 0; i < 3; i++) step("t2_busy");
      if (obs_grant == 2'b01) flash_ready_i = 1'b1;
      else                    luks_ready_i  = 1'b1;
      step("t2_done");
      flash_ready_i = 1'b0;
      luks_ready_i  = 1'b0;
    end
    flash_valid_i = 1'b0;
    luks_valid_i  = 1'b0;
    for (int i = 0; i < 4; i++) step("t2_drain");

    // Sensor timeout with a flash request pending.
    luks_valid_i = 1'b1;
    wait_grant("t3_wait");
    check_vec("t3_grant_luks", obs_grant, 2'b10);
    flash_valid_i = 1'b1;
    n = 1;
    while (!obs_timeout && n < 40) begin
      step("t3_busy");
      n++;
    end
    check_int("t3_timeout_cycle", n, TO);
    luks_valid_i = 1'b0;
    wait_grant("t3_after");
    check_vec("t3_flash_next", obs_grant, 2'b01);
    flash_ready_i = 1'b1;
    step("t3_flash_done");
    flash_ready_i = 1'b0;
    flash_valid_i = 1'b0;

    // Ready arriving on the timeout cycle wins.
    luks_valid_i = 1'b1;
    wait_grant("t4_wait");
    n = 0;
    while (m_age != TO - 1 && n < 40) begin
      step("t4_busy");
      n++;
    end
    luks_ready_i = 1'b1;
    step("t4_collide");
    check_bit("t4_ready", obs_lro, 1'b1);
    check_bit("t4_no_timeout", obs_timeout, 1'b0);
    luks_ready_i = 1'b0;
    luks_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step("t4_drain");

    // Reset in the middle of a flash grant.
    flash_valid_i = 1'b1;
    wait_grant("t6_wait");
    step("t6_busy");
    rstn = 1'b0;
    #1;
    model_reset();
    compare_outputs("t6_async_rst");
    #1;
    rstn = 1'b1;
    luks_valid_i = 1'b1;
    wait_grant("t6_tie");
    check_vec("t6_flash_first", obs_grant, 2'b01);
    flash_ready_i = 1'b1;
    step("t6_done");
    flash_ready_i = 1'b0;
    flash_valid_i = 1'b0;
    luks_valid_i  = 1'b0;

    // Random traffic; requests held until their completion pulse.
    for (int i = 0; i < 600; i++) begin
      if (obs_fro) flash_valid_i = 1'b0;
      else if (!flash_valid_i) flash_valid_i = ($urandom_range(0, 3) == 0);
      if (obs_lro) luks_valid_i = 1'b0;
      else if (!luks_valid_i) luks_valid_i = ($urandom_range(0, 3) == 0);
      flash_ready_i = ($urandom_range(0, 5) == 0);
      luks_ready_i  = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
